clk_div_freq_meter: RTL and testbench

//  Sits downstream of the ripple clock divider and consumes its div2/div4/div8/div16 outputs.

---
 rtl/clk_div_freq_meter.sv | 99 +++++++++
 tb/tb_clk_div_freq_meter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_freq_meter.sv
// Frequency meter for the ripple divider outputs: synchronises each divided clock,
// detects rising edges, and counts ticks of one selected output over a clk-cycle window.
module clk_div_freq_meter #(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       div_in,
  input  logic [1:0]       sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  output logic             busy,
  output logic             edge_tick,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_count,
  output logic             overflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [SYNC_STAGES-1:0][3:0] sync_p0;
  logic [3:0]                  prev_p1;
  logic [3:0]                  tick_p2;
  logic [3:0]                  sync_last;

  logic [1:0]       state;
  logic [1:0]       sel_q;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] count;
  logic             ovf;

  assign sync_last = sync_p0[SYNC_STAGES-1];

  // Synchroniser chain, then edge detect against the previous synchronised value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      prev_p1 <= '0;
      tick_p2 <= '0;
    end else begin
      sync_p0[0] <= div_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_p0[i] <= sync_p0[i-1];
      prev_p1 <= sync_last;
      tick_p2 <= sync_last & ~prev_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= '0;
      win_cnt <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sel_q   <= sel;
            win_cnt <= win_len;
            count   <= '0;
            ovf     <= 1'b0;
            state   <= (win_len != '0) ? MEASURE : DONE;
          end
        end
        MEASURE: begin
          if (tick_p2[sel_q]) begin
            // Saturate; an increment attempted at full scale flags the window
            if (count == {CNT_W{1'b1}})
              ovf <= 1'b1;
            else
              count <= count + 1'b1;
          end
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == WIN_W'(1))
            state <= DONE;
        end
        DONE: begin
          if (meas_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign meas_valid = (state == DONE);
  assign edge_tick  = tick_p2[sel_q];
  assign meas_count = count;
  assign overflow   = ovf;

endmodule

// File: tb/tb_clk_div_freq_meter.sv
// Directed bench for clk_div_freq_meter: a model ripple divider drives div_in,
// each scenario task checks counts, handshake timing and reset behaviour.
module tb_clk_div_freq_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  div_in;
  logic [1:0]  sel;
  logic [15:0] win_len;
  logic        start;
  logic        busy;
  logic        edge_tick;
  logic        meas_valid;
  logic        meas_ready;
  logic [11:0] meas_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [3:0] gen_cnt = 4'd0;

  clk_div_freq_meter #(.SYNC_STAGES(2), .WIN_W(16), .CNT_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_in     (div_in),
    .sel        (sel),
    .win_len    (win_len),
    .start      (start),
    .busy       (busy),
    .edge_tick  (edge_tick),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_count (meas_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Ripple divider model: bit k of the counter has period 2^(k+1) clk cycles
  initial begin
    forever begin
      @(negedge clk);
      gen_cnt = gen_cnt + 4'd1;
    end
  end
  assign div_in = gen_cnt;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] s, input logic [15:0] w);
    @(negedge clk);
    sel     = s;
    win_len = w;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Counts edges after the start edge until meas_valid rises (bounded)
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!meas_valid && n < limit) begin
      step();
      n++;
    end
    if (!meas_valid) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 2'd0; win_len = 16'd0; start = 1'b0; meas_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, edge_tick, meas_valid, meas_count, overflow} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b tick=%b valid=%b count=%0d ovf=%b, want all 0",
               busy, edge_tick, meas_valid, meas_count, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || meas_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b valid=%b, want 0 0", busy, meas_valid);
    end
  endtask

  task automatic test_div2();
    int n;
    int vcnt;
    meas_ready = 1'b0;
    do_start(2'd0, 16'd100);
    wait_valid(200, n);
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL div2_latency: got %0d edges, want 100", n);
    end
    checks++;
    if (meas_count !== 12'd50 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL div2_count: got count=%0d ovf=%b, want 50 0", meas_count, overflow);
    end
    @(negedge clk);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (meas_valid) vcnt++;
      step();
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL div2_valid_once: got %0d extra valid cycles, want 0", vcnt);
    end
    checks++;
    if (meas_count !== 12'd50) begin
      errors++;
      $display("FAIL div2_hold_idle: got count=%0d, want 50", meas_count);
    end
  endtask

  task automatic test_div16();
    int pulses = 0;
    int bad = 0;
    int last = -1;
    logic prev_tick = 1'b0;
    meas_ready = 1'b0;
    do_start(2'd3, 16'd160);
    for (int i = 1; i <= 160; i++) begin
      step();
      if (edge_tick) begin
        if (prev_tick) bad++;
        if (last >= 0 && i - last != 16) bad++;
        last = i;
        pulses++;
      end
      prev_tick = edge_tick;
    end
    checks++;
    if (pulses != 10 || bad != 0) begin
      errors++;
      $display("FAIL div16_tick_shape: got pulses=%0d bad=%0d, want 10 0", pulses, bad);
    end
    checks++;
    if (meas_valid !== 1'b1 || meas_count !== 12'd10 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL div16_count: got valid=%b count=%0d ovf=%b, want 1 10 0",
               meas_valid, meas_count, overflow);
    end
    @(negedge clk);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
  endtask

  task automatic test_saturate();
    int n;
    do_start(2'd0, 16'd10000);
    wait_valid(10100, n);
    checks++;
    if (n != 10000) begin
      errors++;
      $display("FAIL sat_latency: got %0d edges, want 10000", n);
    end
    checks++;
    if (meas_count !== 12'd4095 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_count: got count=%0d ovf=%b, want 4095 1", meas_count, overflow);
    end
    @(negedge clk);
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
  endtask

  task automatic test_zero_window();
    @(negedge clk);
    meas_ready = 1'b1;
    do_start(2'd2, 16'd0);
    checks++;
    if (meas_valid !== 1'b1 || busy !== 1'b1 || meas_count !== 12'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_win_done: got valid=%b busy=%b count=%0d ovf=%b, want 1 1 0 0",
               meas_valid, busy, meas_count, overflow);
    end
    step();
    checks++;
    if (meas_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_win_ready_early: got valid=%b busy=%b, want 0 0", meas_valid, busy);
    end
    meas_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    int bad = 0;
    meas_ready = 1'b0;
    do_start(2'd1, 16'd40);
    wait_valid(100, n);
    checks++;
    if (n != 40 || meas_count !== 12'd10) begin
      errors++;
      $display("FAIL hold_first: got edges=%0d count=%0d, want 40 10", n, meas_count);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start   = (i % 3 == 0);
      sel     = 2'(i);
      win_len = 16'(i);
      step();
      if (meas_valid !== 1'b1 || busy !== 1'b1 || meas_count !== 12'd10 || overflow !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: got %0d unstable cycles, want 0", bad);
    end
    @(negedge clk);
    start      = 1'b1;
    sel        = 2'd0;
    win_len    = 16'd5;
    meas_ready = 1'b1;
    step();
    start      = 1'b0;
    meas_ready = 1'b0;
    checks++;
    if (meas_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got valid=%b busy=%b, want 0 0", meas_valid, busy);
    end
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || meas_count !== 12'd10) begin
      errors++;
      $display("FAIL hold_start_ignored: got busy=%b count=%0d, want 0 10", busy, meas_count);
    end
  endtask

  task automatic test_reset_mid();
    int vcnt = 0;
    meas_ready = 1'b0;
    do_start(2'd0, 16'd100);
    repeat (40) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before: got busy=%b, want 1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, edge_tick, meas_valid, meas_count, overflow} !== 16'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b tick=%b valid=%b count=%0d ovf=%b, want all 0",
               busy, edge_tick, meas_valid, meas_count, overflow);
    end
    repeat (2) step();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (meas_valid || busy) vcnt++;
    end
    checks++;
    if (vcnt != 0) begin
      errors++;
      $display("FAIL midrst_no_result: got %0d busy/valid cycles, want 0", vcnt);
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div16();
    test_saturate();
    test_zero_window();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
